// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Brief    : Samples a multiplexed 3-digit active-low seven-segment scan,
//            decodes each settled digit back to a hex nibble and reports
//            complete 12-bit frames, bad frames and scan stalls.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  anodes_in,
  input  logic [7:0]  cathodes_in,
  output logic [11:0] value,
  output logic        value_valid,
  output logic        digit_err,
  output logic        stall
);

  localparam logic [1:0]  c_WAIT   = 2'd0;
  localparam logic [1:0]  c_SETTLE = 2'd1;
  localparam logic [1:0]  c_HOLD   = 2'd2;

  // Settle count compared one wider so SETTLE_CYCLES = 255 cannot wrap.
  localparam logic [8:0]  c_SETTLE_CNT = 9'(SETTLE_CYCLES);
  // With a one-cycle settle the very first synced cycle of a select captures.
  localparam logic        c_SETTLE_ONE = (SETTLE_CYCLES == 1);
  localparam logic [23:0] c_TIMEOUT    = 24'(TIMEOUT_CYCLES);

  // Decode an active-low g..a pattern: {valid, nibble}; invalid gives 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = {1'b1, 4'h0};
      7'h79:   res = {1'b1, 4'h1};
      7'h24:   res = {1'b1, 4'h2};
      7'h30:   res = {1'b1, 4'h3};
      7'h19:   res = {1'b1, 4'h4};
      7'h12:   res = {1'b1, 4'h5};
      7'h02:   res = {1'b1, 4'h6};
      7'h78:   res = {1'b1, 4'h7};
      7'h00:   res = {1'b1, 4'h8};
      7'h18:   res = {1'b1, 4'h9};
      7'h08:   res = {1'b1, 4'hA};
      7'h03:   res = {1'b1, 4'hB};
      7'h46:   res = {1'b1, 4'hC};
      7'h21:   res = {1'b1, 4'hD};
      7'h06:   res = {1'b1, 4'hE};
      7'h0E:   res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [2:0]  an_meta_q, an_sync_q;
  logic [7:0]  ca_meta_q, ca_sync_q;

  logic [1:0]  state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        w_an_valid;
  logic        w_settle_done;
  logic        w_new_sel;
  logic        w_capture;

  logic [4:0]  w_dec;
  logic [3:0]  w_nib;
  logic [2:0]  w_slot;
  logic [2:0]  w_mask_m;
  logic        w_err_m;
  logic [11:0] w_shadow_m;
  logic        w_unused_dp;

  logic [11:0] shadow_q;
  logic [2:0]  mask_q;
  logic        err_q;
  logic [23:0] tcnt_q;
  logic [11:0] value_q;
  logic        value_valid_q;
  logic        digit_err_q;
  logic        stall_q;

  // Two-flop synchronizer on every scan line; idle state is all lines high.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_meta_q <= 3'b111;
      an_sync_q <= 3'b111;
      ca_meta_q <= 8'hFF;
      ca_sync_q <= 8'hFF;
    end else begin
      an_meta_q <= anodes_in;
      an_sync_q <= an_meta_q;
      ca_meta_q <= cathodes_in;
      ca_sync_q <= ca_meta_q;
    end
  end

  // The decimal point carries no digit information.
  assign w_unused_dp   = ca_sync_q[7];

  assign w_an_valid    = (an_sync_q == 3'b011) || (an_sync_q == 3'b101) ||
                         (an_sync_q == 3'b110);
  // cnt_q counts held synced cycles before this one, so +1 includes it.
  assign w_settle_done = (({1'b0, cnt_q} + 9'd1) == c_SETTLE_CNT);

  // FSM state register with the dwell's select value and settle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_WAIT;
      sel_q   <= 3'b111;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: new select starts a dwell, blank aborts, settle counts up.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (w_new_sel) begin
      sel_d = an_sync_q;
      if (c_SETTLE_ONE) begin
        state_d = c_HOLD;
        cnt_d   = 8'd0;
      end else begin
        state_d = c_SETTLE;
        cnt_d   = 8'd1;
      end
    end else if ((state_q != c_WAIT) && (an_sync_q != sel_q)) begin
      state_d = c_WAIT;
      cnt_d   = 8'd0;
    end else if (state_q == c_SETTLE) begin
      if (w_settle_done) begin
        state_d = c_HOLD;
        cnt_d   = 8'd0;
      end else begin
        cnt_d   = cnt_q + 8'd1;
      end
    end else if ((state_q != c_WAIT) && (state_q != c_HOLD)) begin
      state_d = c_WAIT;
      cnt_d   = 8'd0;
    end
  end

  // FSM outputs: detect a fresh dwell and decide when cathodes are captured.
  always_comb begin
    w_new_sel = w_an_valid && ((state_q == c_WAIT) || (an_sync_q != sel_q));
    w_capture = (w_new_sel && c_SETTLE_ONE) ||
                ((state_q == c_SETTLE) && (an_sync_q == sel_q) && w_settle_done);
  end

  // Merge the digit being captured into the frame under assembly.
  always_comb begin
    w_dec      = seg_decode(ca_sync_q[6:0]);
    w_nib      = w_dec[3:0];
    // A valid select has exactly one low anode, so its inverse is the slot.
    w_slot     = ~an_sync_q;
    w_mask_m   = mask_q | w_slot;
    w_err_m    = err_q | ~w_dec[4];
    w_shadow_m = shadow_q;
    if (w_slot[0]) w_shadow_m[3:0]  = w_nib;
    if (w_slot[1]) w_shadow_m[7:4]  = w_nib;
    if (w_slot[2]) w_shadow_m[11:8] = w_nib;
  end

  // Frame assembly, completion pulses and the no-capture stall timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q      <= 12'h000;
      mask_q        <= 3'b000;
      err_q         <= 1'b0;
      tcnt_q        <= 24'd0;
      value_q       <= 12'h000;
      value_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
      if (w_capture) begin
        shadow_q <= w_shadow_m;
        tcnt_q   <= 24'd0;
        stall_q  <= 1'b0;
        if (w_mask_m == 3'b111) begin
          mask_q <= 3'b000;
          err_q  <= 1'b0;
          if (w_err_m) begin
            digit_err_q   <= 1'b1;
          end else begin
            value_q       <= w_shadow_m;
            value_valid_q <= 1'b1;
          end
        end else begin
          mask_q <= w_mask_m;
          err_q  <= w_err_m;
        end
      end else if (tcnt_q == c_TIMEOUT) begin
        // Saturated: flag the stall and drop any partial frame.
        stall_q <= 1'b1;
        mask_q  <= 3'b000;
        err_q   <= 1'b0;
      end else begin
        tcnt_q  <= tcnt_q + 24'd1;
      end
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign digit_err   = digit_err_q;
  assign stall       = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Brief    : Self-checking bench for seg_scan_decoder: vector table, directed
//            stall / reset sequences and random scans against a dwell model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam int T = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  anodes_in = 3'b111;
  logic [7:0]  cathodes_in = 8'hFF;
  logic [11:0] value;
  logic        value_valid;
  logic        digit_err;
  logic        stall;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .anodes_in   (anodes_in),
    .cathodes_in (cathodes_in),
    .value       (value),
    .value_valid (value_valid),
    .digit_err   (digit_err),
    .stall       (stall)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] seg_tab [16];

  // Reference model: synced lines, run length of the synced anode value,
  // per-digit frame slots, idle-cycle count.
  logic [2:0]  m_s1, m_s2;
  logic [7:0]  m_c1, m_c2;
  int          m_run;
  logic [3:0]  m_dig [3];
  logic [2:0]  m_seen;
  logic        m_err;
  logic [11:0] m_value;
  logic        m_vv, m_de, m_stall;
  int          m_idle;

  int vv_cnt, de_cnt, vv_at;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_s1 = 3'b111; m_s2 = 3'b111; m_c1 = 8'hFF; m_c2 = 8'hFF;
    m_run = 1; m_seen = 3'b000; m_err = 1'b0;
    for (int i = 0; i < 3; i++) m_dig[i] = 4'h0;
    m_value = 12'h000; m_vv = 1'b0; m_de = 1'b0; m_stall = 1'b0; m_idle = 0;
  endtask

  // One clock edge of the model, using the inputs presented before the edge.
  task automatic model_step();
    logic       valid, cap, ok;
    logic [3:0] nib;
    int         idx;
    logic [2:0] ns2;
    if (reset) begin
      model_reset();
      return;
    end
    valid = (m_s2 == 3'b011) || (m_s2 == 3'b101) || (m_s2 == 3'b110);
    // The pattern has been held S synced cycles exactly now.
    cap   = valid && (m_run == S);
    m_vv  = 1'b0;
    m_de  = 1'b0;
    if (cap) begin
      ok = 1'b0; nib = 4'h0;
      for (int i = 0; i < 16; i++)
        if (seg_tab[i] == m_c2[6:0]) begin ok = 1'b1; nib = 4'(i); end
      idx = (m_s2 == 3'b110) ? 0 : (m_s2 == 3'b101) ? 1 : 2;
      m_dig[idx]  = nib;
      m_seen[idx] = 1'b1;
      if (!ok) m_err = 1'b1;
      m_idle  = 0;
      m_stall = 1'b0;
      if (m_seen == 3'b111) begin
        if (m_err) m_de = 1'b1;
        else begin
          m_value = {m_dig[2], m_dig[1], m_dig[0]};
          m_vv    = 1'b1;
        end
        m_seen = 3'b000; m_err = 1'b0;
      end
    end else if (m_idle == T) begin
      m_stall = 1'b1; m_seen = 3'b000; m_err = 1'b0;
    end else begin
      m_idle++;
    end
    ns2   = m_s1;
    m_run = (ns2 == m_s2) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_s2  = ns2;
    m_s1  = anodes_in;
    m_c2  = m_c1;
    m_c1  = cathodes_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("value", value, m_value);
    check("value_valid", value_valid, m_vv);
    check("digit_err", digit_err, m_de);
    check("stall", stall, m_stall);
    if (value_valid) vv_cnt++;
    if (digit_err) de_cnt++;
  endtask

  // Present one anode/cathode pair for n cycles; vv_at = tick of last pulse.
  task automatic dwell(input logic [2:0] a, input logic [7:0] c, input int n);
    anodes_in   = a;
    cathodes_in = c;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (value_valid) vv_at = k;
    end
  endtask

  typedef struct {
    logic [2:0]  an;
    logic [7:0]  ca;
    int          cyc;
    logic [11:0] exp_val;
    int          exp_vv;
    int          exp_de;
    int          exp_at;
  } vec_t;

  vec_t tbl [11];

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h18; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;

    tbl[0]  = '{3'b110, 8'hF8, 10, 12'h000, 0, 0, 0};
    tbl[1]  = '{3'b101, 8'h88, 10, 12'h000, 0, 0, 0};
    tbl[2]  = '{3'b011, 8'hB0, 10, 12'h3A7, 1, 0, 6};
    tbl[3]  = '{3'b110, 8'hF8, 10, 12'h3A7, 0, 0, 0};
    tbl[4]  = '{3'b101, 8'hFF, 10, 12'h3A7, 0, 0, 0};
    tbl[5]  = '{3'b011, 8'hB0, 10, 12'h3A7, 0, 1, 0};
    tbl[6]  = '{3'b110, 8'hC0,  3, 12'h3A7, 0, 0, 0};
    tbl[7]  = '{3'b111, 8'hFF,  4, 12'h3A7, 0, 0, 0};
    tbl[8]  = '{3'b110, 8'hC0, 10, 12'h3A7, 0, 0, 0};
    tbl[9]  = '{3'b101, 8'hF9, 10, 12'h3A7, 0, 0, 0};
    tbl[10] = '{3'b011, 8'hA4, 10, 12'h210, 1, 0, 6};

    model_reset();
    vv_cnt = 0; de_cnt = 0; vv_at = 0;

    // Reset held three cycles with arbitrary inputs.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      anodes_in   = 3'($urandom);
      cathodes_in = 8'($urandom);
      tick();
    end
    check("rst_value", value, 12'h000);
    check("rst_value_valid", value_valid, 1'b0);
    check("rst_digit_err", digit_err, 1'b0);
    check("rst_stall", stall, 1'b0);
    reset = 1'b0;

    // Table: good frame, bad digit frame, glitch then frame 210.
    for (int r = 0; r < 11; r++) begin
      vv_cnt = 0; de_cnt = 0; vv_at = 0;
      dwell(tbl[r].an, tbl[r].ca, tbl[r].cyc);
      check($sformatf("tbl%0d_value", r), value, tbl[r].exp_val);
      check($sformatf("tbl%0d_vv_count", r), vv_cnt, tbl[r].exp_vv);
      check($sformatf("tbl%0d_de_count", r), de_cnt, tbl[r].exp_de);
      check($sformatf("tbl%0d_vv_tick", r), vv_at, tbl[r].exp_at);
    end

    // Stall: two digits, then blank until the timer saturates.
    dwell(3'b110, 8'hC0, 10);
    dwell(3'b101, 8'hF9, 10);
    anodes_in = 3'b111; cathodes_in = 8'hFF;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 16) check("stall_before_timeout", stall, 1'b0);
      if (k == 17) check("stall_rise", stall, 1'b1);
    end
    check("stall_held", stall, 1'b1);
    vv_cnt = 0;
    dwell(3'b011, 8'hB0, 10);
    check("stall_partial_discarded", vv_cnt, 0);
    check("stall_cleared", stall, 1'b0);
    vv_cnt = 0;
    dwell(3'b110, 8'hF9, 10);
    dwell(3'b101, 8'hA4, 10);
    dwell(3'b011, 8'hB0, 10);
    check("post_stall_vv_count", vv_cnt, 1);
    check("post_stall_value", value, 12'h321);

    // Reset mid-frame discards the two captured digits.
    dwell(3'b110, 8'hF8, 10);
    dwell(3'b101, 8'h88, 10);
    reset = 1'b1; anodes_in = 3'b111;
    tick();
    reset = 1'b0;
    vv_cnt = 0;
    dwell(3'b011, 8'hB0, 10);
    check("midrst_no_vv", vv_cnt, 0);
    check("midrst_value", value, 12'h000);
    vv_cnt = 0;
    dwell(3'b110, 8'hF8, 10);
    dwell(3'b101, 8'h88, 10);
    dwell(3'b011, 8'hB0, 10);
    check("midrst_frame_vv", vv_cnt, 1);
    check("midrst_frame_value", value, 12'h3A7);

    // Random scans: valid, blank and multi-low selects, bad patterns,
    // mid-dwell cathode changes, long blanks and occasional resets.
    for (int it = 0; it < 300; it++) begin
      logic [2:0] a;
      logic [7:0] c;
      int sel, n;
      sel = $urandom_range(0, 9);
      case (sel)
        0: a = 3'b011;
        1: a = 3'b101;
        2: a = 3'b110;
        3: a = 3'b111;
        4: a = 3'($urandom);
        default: begin
          int j;
          j = $urandom_range(0, 2);
          a = (j == 0) ? 3'b110 : (j == 1) ? 3'b101 : 3'b011;
        end
      endcase
      if ($urandom_range(0, 9) < 8) c = {1'($urandom), seg_tab[$urandom_range(0, 15)]};
      else c = 8'($urandom);
      n = $urandom_range(1, 12);
      dwell(a, c, n);
      if ($urandom_range(0, 3) == 0)
        dwell(a, {1'($urandom), seg_tab[$urandom_range(0, 15)]}, $urandom_range(1, 6));
      if ($urandom_range(0, 29) == 0) dwell(3'b111, 8'hFF, 25);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
